// File: rtl/muldiv_hilo_unit_if.sv
// Request/response bundle between the core controller and the multiply/divide unit.
// The master drives the request; the slave returns status and the HI/LO registers.
interface muldiv_hilo_unit_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [2:0]      op;
   logic [XLEN-1:0] srca;
   logic [XLEN-1:0] srcb;
   logic            busy;
   logic            done;
   logic            div_by_zero;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;

   modport master (
      output start, op, srca, srcb,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, srca, srcb,
      output busy, done, div_by_zero, hi, lo
   );
endinterface

// File: rtl/muldiv_hilo_unit.sv
// Iterative shift-add multiplier / restoring divider that owns the HI/LO pair.
// It retires STEP bits per RUN cycle and applies sign fix-up in a final FIX cycle.
module muldiv_hilo_unit #(
   parameter int XLEN = 32,
   parameter int STEP = 1
) (
   input  logic              clk,
   input  logic              reset,
   muldiv_hilo_unit_if.slave bus
);
   localparam int N  = XLEN / STEP;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic              is_div_q, is_div_d;
   logic              neg_res_q, neg_res_d;
   logic              neg_rem_q, neg_rem_d;
   logic              dz_q, dz_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              dbz_q, dbz_d;
   logic [XLEN-1:0]   hi_q, hi_d;
   logic [XLEN-1:0]   lo_q, lo_d;

   logic              sgn, a_neg, b_neg;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic [XLEN+STEP-1:0] mul_sum;
   logic [2*XLEN-1:0] div_acc;
   logic [XLEN:0]     div_r;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo, rem;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      b_d       = b_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      dbz_d     = dbz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;

      sgn   = ~bus.op[0];
      a_neg = sgn & bus.srca[XLEN-1];
      b_neg = sgn & bus.srcb[XLEN-1];
      a_mag = a_neg ? (~bus.srca + 1'b1) : bus.srca;
      b_mag = b_neg ? (~bus.srcb + 1'b1) : bus.srcb;

      // Multiply: low half of acc holds the unconsumed multiplier bits.
      mul_sum = {{STEP{1'b0}}, acc_q[2*XLEN-1:XLEN]};
      for (int unsigned j = 0; j < STEP; j++) begin
         if (acc_q[j])
            mul_sum = mul_sum + ({{STEP{1'b0}}, b_q} << j);
      end

      // Divide: upper half of acc is the partial remainder, lower half dividend/quotient.
      div_acc = acc_q;
      for (int unsigned j = 0; j < STEP; j++) begin
         div_r   = div_acc[2*XLEN-1:XLEN-1];
         div_acc = div_acc << 1;
         if (div_r >= {1'b0, b_q}) begin
            div_r      = div_r - {1'b0, b_q};
            div_acc[0] = 1'b1;
         end
         div_acc[2*XLEN-1:XLEN] = div_r[XLEN-1:0];
      end

      prod = neg_res_q ? (~acc_q + 1'b1) : acc_q;
      quo  = neg_res_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
      rem  = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               case (bus.op)
                  3'b000, 3'b001, 3'b010, 3'b011: begin
                     acc_d     = {{XLEN{1'b0}}, a_mag};
                     b_d       = b_mag;
                     is_div_d  = bus.op[1];
                     neg_res_d = a_neg ^ b_neg;
                     neg_rem_d = a_neg;
                     dz_d      = (bus.srcb == '0);
                     cnt_d     = '0;
                     busy_d    = 1'b1;
                     dbz_d     = 1'b0;
                     state_d   = RUN;
                  end
                  3'b100:  hi_d = bus.srca;
                  3'b101:  lo_d = bus.srca;
                  default: ;
               endcase
            end
         end
         RUN: begin
            acc_d = is_div_q ? div_acc : {mul_sum, acc_q[XLEN-1:STEP]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(N - 1))
               state_d = FIX;
         end
         FIX: begin
            // A zero divisor leaves the dividend magnitude as remainder; re-signing it restores srca.
            if (is_div_q) begin
               hi_d  = rem;
               lo_d  = dz_q ? '1 : quo;
               dbz_d = dz_q;
            end else begin
               hi_d = prod[2*XLEN-1:XLEN];
               lo_d = prod[XLEN-1:0];
            end
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         b_q       <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         b_q       <= b_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         dbz_q     <= dbz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Scoreboard bench for muldiv_hilo_unit: STEP=1 and STEP=4 instances side by side.
// Stimulus pushes expected HI/LO/flag; per-instance monitors pop on each done pulse.
module tb_muldiv_hilo_unit;
   logic clk;
   logic reset;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   muldiv_hilo_unit_if #(.XLEN(32)) bus1 ();
   muldiv_hilo_unit_if #(.XLEN(32)) bus4 ();

   muldiv_hilo_unit #(.XLEN(32), .STEP(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
   muldiv_hilo_unit #(.XLEN(32), .STEP(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      string       name;
   } exp_t;

   exp_t q1[$];
   exp_t q4[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   done_cnt1  = 0;
   int   done_cnt4  = 0;
   int   busy_cyc1  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
      end
   endtask

   task automatic mon_cmp(input int which, input logic [31:0] hi, input logic [31:0] lo,
                          input logic dz);
      exp_t e;
      if ((which == 1 && q1.size() == 0) || (which == 4 && q4.size() == 0)) begin
         compared++;
         mismatched++;
         $display("FAIL unexpected_done dut%0d: got done=1 required no pulse", which);
      end else begin
         e = (which == 1) ? q1.pop_front() : q4.pop_front();
         check({e.name, ".hi"}, hi, e.hi);
         check({e.name, ".lo"}, lo, e.lo);
         check({e.name, ".dz"}, {31'b0, dz}, {31'b0, e.dz});
      end
   endtask

   always @(negedge clk) begin
      if (bus1.busy) busy_cyc1++;
      if (bus1.done) begin
         done_cnt1++;
         mon_cmp(1, bus1.hi, bus1.lo, bus1.div_by_zero);
      end
      if (bus4.done) begin
         done_cnt4++;
         mon_cmp(4, bus4.hi, bus4.lo, bus4.div_by_zero);
      end
   end

   // Drives one request at the next rising edge, optionally recording its expected result.
   task automatic issue(input int which, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit push, input exp_t e);
      @(negedge clk);
      if (which == 1) begin
         bus1.start = 1'b1; bus1.op = op; bus1.srca = a; bus1.srcb = b;
         if (push) q1.push_back(e);
      end else begin
         bus4.start = 1'b1; bus4.op = op; bus4.srca = a; bus4.srcb = b;
         if (push) q4.push_back(e);
      end
      @(posedge clk);
      #1;
      bus1.start = 1'b0;
      bus4.start = 1'b0;
   endtask

   task automatic drain(input int which, input string name);
      int n = 0;
      while (n < 200 && ((which == 1) ? q1.size() : q4.size()) != 0) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      #1;
      compared++;
      if (((which == 1) ? q1.size() : q4.size()) != 0) begin
         mismatched++;
         $display("FAIL %s_timeout: got no done within 200 cycles required done", name);
      end
   endtask

   task automatic run_op(input int which, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edz, input string name);
      exp_t e;
      e.hi = ehi; e.lo = elo; e.dz = edz; e.name = name;
      issue(which, op, a, b, 1'b1, e);
      drain(which, name);
   endtask

   initial begin
      exp_t e;
      int   d0;
      int   lat;
      e.hi = '0; e.lo = '0; e.dz = 1'b0; e.name = "none";
      bus1.start = 1'b0; bus1.op = 3'b111; bus1.srca = '0; bus1.srcb = '0;
      bus4.start = 1'b0; bus4.op = 3'b111; bus4.srca = '0; bus4.srcb = '0;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("rst.hi", bus1.hi, 32'h0);
      check("rst.lo", bus1.lo, 32'h0);
      check("rst.flags", {29'b0, bus1.busy, bus1.done, bus1.div_by_zero}, 32'h0);

      busy_cyc1 = 0;
      d0 = done_cnt1;
      run_op(1, 3'b000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mult_m3x7");
      check("mult_busy_cycles", busy_cyc1, 33);
      check("mult_done_pulses", done_cnt1 - d0, 1);

      run_op(1, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max");
      run_op(1, 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0, "mult_m1xm1");
      run_op(1, 3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_m7d2");
      run_op(1, 3'b010, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 1'b0, "div_7dm2");
      run_op(1, 3'b011, 32'd7, 32'd2, 32'h1, 32'h3, 1'b0, "divu_7d2");
      run_op(1, 3'b011, 32'd5, 32'd0, 32'h5, 32'hFFFFFFFF, 1'b1, "divu_5d0");
      run_op(1, 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, "div_ovf");

      // Second request lands while busy and must be ignored.
      d0 = done_cnt1;
      e.hi = 32'h0; e.lo = 32'd12; e.dz = 1'b0; e.name = "multu_3x4";
      issue(1, 3'b001, 32'd3, 32'd4, 1'b1, e);
      repeat (4) @(posedge clk);
      issue(1, 3'b011, 32'd9, 32'd3, 1'b0, e);
      drain(1, "multu_3x4");
      repeat (40) @(posedge clk);
      #1;
      check("ignored_start_pulses", done_cnt1 - d0, 1);
      check("ignored_start.lo", bus1.lo, 32'd12);

      issue(1, 3'b100, 32'hDEADBEEF, 32'h0, 1'b0, e);
      check("mthi.hi", bus1.hi, 32'hDEADBEEF);
      check("mthi.lo", bus1.lo, 32'd12);
      check("mthi.busy", {31'b0, bus1.busy}, 32'h0);
      issue(1, 3'b101, 32'h01234567, 32'h0, 1'b0, e);
      check("mtlo.lo", bus1.lo, 32'h01234567);
      issue(1, 3'b110, 32'hAAAAAAAA, 32'h0, 1'b0, e);
      check("nop.hi", bus1.hi, 32'hDEADBEEF);
      check("nop.busy", {31'b0, bus1.busy}, 32'h0);

      // Reset mid-operation abandons the result.
      d0 = done_cnt1;
      issue(1, 3'b001, 32'h10000, 32'h10000, 1'b0, e);
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      check("midrst.hi", bus1.hi, 32'h0);
      check("midrst.lo", bus1.lo, 32'h0);
      check("midrst.busy", {31'b0, bus1.busy}, 32'h0);
      repeat (40) @(posedge clk);
      #1;
      check("midrst_no_done", done_cnt1 - d0, 0);

      e.hi = 32'h1; e.lo = 32'h23456780; e.dz = 1'b0; e.name = "step4_multu";
      issue(4, 3'b001, 32'h12345678, 32'h10, 1'b1, e);
      lat = 0;
      while (lat < 50 && !bus4.done) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("step4_latency", lat, 9);
      drain(4, "step4_multu");
      run_op(4, 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "step4_divu");
      run_op(4, 3'b010, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0, "step4_div");

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
